// File: rtl/red_pitaya_top_core.sv
// red_pitaya_top_core: ADC DDR deserializer, trigger/temp/PLL-ref conditioning and housekeeping registers
module red_pitaya_top_core #(
  parameter logic [31:0] ID      = 32'h0000_0001,
  parameter int          REF_NOM = 25,
  parameter int          REF_TOL = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [1:0][6:0]  adc_dat_i,
  output logic [1:0][13:0] adc_dat_o,
  input  logic             trig_i,
  output logic             trig_o,
  input  logic [1:0]       temp_prot_i,
  output logic             temp_alarm_o,
  input  logic             pll_ref_i,
  output logic             pll_lo_o,
  output logic             pll_hi_o,
  input  logic [8:0]       exp_p_i,
  input  logic [8:0]       exp_n_i,
  output logic [8:0]       exp_p_o,
  output logic [8:0]       exp_n_o,
  output logic [8:0]       exp_p_oe,
  output logic [8:0]       exp_n_oe,
  output logic [7:0]       led_o,
  input  logic [31:0]      sys_addr,
  input  logic [31:0]      sys_wdata,
  input  logic             sys_wen,
  input  logic             sys_ren,
  output logic [31:0]      sys_rdata,
  output logic             sys_ack,
  output logic             sys_err
);
  localparam logic [15:0] HI_LIM = 16'(REF_NOM + REF_TOL);
  localparam logic [15:0] LO_LIM = 16'(REF_NOM - REF_TOL);
  localparam logic [15:0] TMO    = 16'(4 * REF_NOM);
  logic [1:0][6:0]  neg_q, even_q, odd_q;
  logic [1:0][13:0] raw;
  logic [2:0]       trig_s;
  logic [1:0]       temp_s1, temp_s2;
  logic [2:0]       ref_s;
  logic [8:0]       exp_p_s1, exp_p_s2, exp_n_s1, exp_n_s2;
  logic [31:0]      trig_cnt, rd_val;
  logic [15:0]      cnt;
  logic [2:0]       lock_cnt;
  logic             temp_sticky, armed, lock, mapped, ref_rise, in_win;
  logic [7:0]       a;
  logic             unused;
  assign unused = ^{sys_addr[31:8], sys_wdata[31:9]};
  assign a = sys_addr[7:0];
  assign trig_o = trig_s[1] & ~trig_s[2];
  assign temp_alarm_o = temp_sticky;
  assign ref_rise = ref_s[1] & ~ref_s[2];
  assign in_win = (cnt <= HI_LIM) && (cnt >= LO_LIM);
  assign lock = lock_cnt == 3'd4;
  // even bits are sampled half a cycle before their odd partners
  always_ff @(negedge clk_i or negedge rstn_i)
    if (!rstn_i) neg_q <= '0;
    else neg_q <= adc_dat_i;
  always_comb begin
    raw = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 7; i++) begin
        raw[c][2*i]   = even_q[c][i];
        raw[c][2*i+1] = odd_q[c][i];
      end
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      even_q    <= '0;
      odd_q     <= '0;
      adc_dat_o <= '0;
    end else begin
      even_q <= neg_q;
      odd_q  <= adc_dat_i;
      for (int c = 0; c < 2; c++) adc_dat_o[c] <= {raw[c][13], ~raw[c][12:0]};
    end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      trig_s   <= '0;
      trig_cnt <= '0;
      temp_s1  <= '0;
      temp_s2  <= '0;
      exp_p_s1 <= '0;
      exp_p_s2 <= '0;
      exp_n_s1 <= '0;
      exp_n_s2 <= '0;
    end else begin
      trig_s   <= {trig_s[1:0], trig_i};
      trig_cnt <= trig_cnt + {31'd0, trig_o};
      temp_s1  <= temp_prot_i;
      temp_s2  <= temp_s1;
      exp_p_s1 <= exp_p_i;
      exp_p_s2 <= exp_p_s1;
      exp_n_s1 <= exp_n_i;
      exp_n_s2 <= exp_n_s1;
    end
  // period counter saturates at the timeout; the first edge after reset or timeout only arms it
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      ref_s    <= '0;
      cnt      <= '0;
      armed    <= 1'b0;
      lock_cnt <= '0;
      pll_hi_o <= 1'b0;
      pll_lo_o <= 1'b0;
    end else begin
      ref_s <= {ref_s[1:0], pll_ref_i};
      if (ref_rise) begin
        cnt   <= 16'd1;
        armed <= 1'b1;
        if (armed) begin
          pll_hi_o <= cnt > HI_LIM;
          pll_lo_o <= cnt < LO_LIM;
          lock_cnt <= !in_win ? 3'd0 : lock ? lock_cnt : lock_cnt + 3'd1;
        end
      end else if (cnt == TMO) begin
        armed    <= 1'b0;
        lock_cnt <= '0;
        pll_hi_o <= 1'b0;
        pll_lo_o <= 1'b0;
      end else cnt <= cnt + 16'd1;
    end
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (a)
      8'h00: rd_val = ID;
      8'h10: rd_val = {23'd0, exp_p_oe};
      8'h14: rd_val = {23'd0, exp_n_oe};
      8'h18: rd_val = {23'd0, exp_p_o};
      8'h1C: rd_val = {23'd0, exp_n_o};
      8'h20: rd_val = {23'd0, exp_p_s2};
      8'h24: rd_val = {23'd0, exp_n_s2};
      8'h30: rd_val = {24'd0, led_o};
      8'h40: rd_val = {30'd0, lock, temp_sticky};
      8'h44: rd_val = trig_cnt;
      default: mapped = 1'b0;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      exp_p_oe    <= '0;
      exp_n_oe    <= '0;
      exp_p_o     <= '0;
      exp_n_o     <= '0;
      led_o       <= '0;
      temp_sticky <= 1'b0;
      sys_ack     <= 1'b0;
      sys_err     <= 1'b0;
      sys_rdata   <= '0;
    end else begin
      if (sys_wen)
        case (a)
          8'h10: exp_p_oe <= sys_wdata[8:0];
          8'h14: exp_n_oe <= sys_wdata[8:0];
          8'h18: exp_p_o  <= sys_wdata[8:0];
          8'h1C: exp_n_o  <= sys_wdata[8:0];
          8'h30: led_o    <= sys_wdata[7:0];
          default: ;
        endcase
      temp_sticky <= |temp_s2 | (temp_sticky & ~(sys_wen && a == 8'h40 && sys_wdata[0]));
      sys_ack     <= sys_wen | sys_ren;
      sys_err     <= (sys_wen | sys_ren) & ~mapped;
      sys_rdata   <= sys_ren ? rd_val : '0;
    end
endmodule

// File: tb/tb_red_pitaya_top_core.sv
// tb_red_pitaya_top_core: randomized self-checking bench against a behavioural model
module tb_red_pitaya_top_core;
  localparam logic [31:0] ID = 32'h0000_0001;
  localparam int NOM = 25, TOL = 1, CLK = 40;
  logic             clk_i = 0, rstn_i = 0;
  logic [1:0][6:0]  adc_dat_i = '0;
  logic [1:0][13:0] adc_dat_o;
  logic             trig_i = 0, trig_o;
  logic [1:0]       temp_prot_i = '0;
  logic             temp_alarm_o, pll_ref_i = 0, pll_lo_o, pll_hi_o;
  logic [8:0]       exp_p_i = '0, exp_n_i = '0, exp_p_o, exp_n_o, exp_p_oe, exp_n_oe;
  logic [7:0]       led_o;
  logic [31:0]      sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic             sys_wen = 0, sys_ren = 0, sys_ack, sys_err;
  int n_chk = 0, n_pass = 0, trig_seen = 0, ref_period = 0;
  logic [8:0]  m_poe, m_noe, m_po, m_no;
  logic [7:0]  m_led;
  logic        m_temp, m_lock;
  logic [31:0] m_trig;
  red_pitaya_top_core #(.ID(ID), .REF_NOM(NOM), .REF_TOL(TOL)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .adc_dat_i(adc_dat_i), .adc_dat_o(adc_dat_o),
    .trig_i(trig_i), .trig_o(trig_o), .temp_prot_i(temp_prot_i), .temp_alarm_o(temp_alarm_o),
    .pll_ref_i(pll_ref_i), .pll_lo_o(pll_lo_o), .pll_hi_o(pll_hi_o),
    .exp_p_i(exp_p_i), .exp_n_i(exp_n_i), .exp_p_o(exp_p_o), .exp_n_o(exp_n_o),
    .exp_p_oe(exp_p_oe), .exp_n_oe(exp_n_oe), .led_o(led_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err)
  );
  always #(CLK/2) clk_i = ~clk_i;
  always @(negedge clk_i) if (trig_o) trig_seen++;
  initial forever
    if (ref_period == 0) begin
      pll_ref_i = 0;
      @(posedge clk_i);
    end else begin
      pll_ref_i = 1;
      #(ref_period/2);
      pll_ref_i = 0;
      #(ref_period - ref_period/2);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic bus(input logic w, input logic r, input logic [31:0] ad, input logic [31:0] d,
                     output logic [31:0] rd, output logic ack, output logic err);
    @(posedge clk_i); #1;
    sys_wen = w; sys_ren = r; sys_addr = ad; sys_wdata = d;
    @(posedge clk_i); #1;
    sys_wen = 0; sys_ren = 0;
    rd = sys_rdata; ack = sys_ack; err = sys_err;
  endtask
  function automatic logic is_mapped(input logic [7:0] ad);
    return ad inside {8'h00, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h30, 8'h40, 8'h44};
  endfunction
  function automatic logic [31:0] model_read(input logic [7:0] ad);
    case (ad)
      8'h00: return ID;
      8'h10: return 32'(m_poe);
      8'h14: return 32'(m_noe);
      8'h18: return 32'(m_po);
      8'h1C: return 32'(m_no);
      8'h20: return 32'(exp_p_i);
      8'h24: return 32'(exp_n_i);
      8'h30: return 32'(m_led);
      8'h40: return {30'd0, m_lock, m_temp};
      8'h44: return m_trig;
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_write(input logic [7:0] ad, input logic [31:0] d);
    case (ad)
      8'h10: m_poe = d[8:0];
      8'h14: m_noe = d[8:0];
      8'h18: m_po = d[8:0];
      8'h1C: m_no = d[8:0];
      8'h30: m_led = d[7:0];
      8'h40: if (d[0] && temp_prot_i == 0) m_temp = 0;
      default: ;
    endcase
  endtask
  function automatic logic [6:0] lane(input logic [13:0] r, input int odd);
    logic [6:0] l;
    for (int i = 0; i < 7; i++) l[i] = r[2*i+odd];
    return l;
  endfunction
  function automatic logic [13:0] conv(input logic [13:0] r);
    return {r[13], ~r[12:0]};
  endfunction
  task automatic pll_step(input int period);
    logic [31:0] rd;
    logic ack, err;
    real pc;
    ref_period = period;
    #(period * 8 + 400);
    pc = real'(period) / CLK;
    m_lock = pc >= NOM - TOL && pc <= NOM + TOL;
    check("pll_hi", 32'(pll_hi_o), 32'(pc > NOM + TOL + 1));
    check("pll_lo", 32'(pll_lo_o), 32'(pc < NOM - TOL - 1));
    bus(0, 1, 32'h40, 0, rd, ack, err);
    check("pll_lock", 32'(rd[1]), 32'(m_lock));
  endtask
  initial begin
    logic [31:0] rd, ad, d;
    logic ack, err, w, r;
    logic [13:0] q0[$], q1[$];
    int n, t0;
    m_poe = 0; m_noe = 0; m_po = 0; m_no = 0; m_led = 0; m_temp = 0; m_lock = 0; m_trig = 0;
    cyc(3);
    check("rst_adc", 32'(adc_dat_o), 0);
    check("rst_misc", {26'd0, trig_o, temp_alarm_o, pll_lo_o, pll_hi_o, sys_ack, sys_err}, 0);
    check("rst_exp", {exp_p_o, exp_n_o, exp_p_oe, exp_n_oe}, 0);
    check("rst_led_rdata", sys_rdata | 32'(led_o), 0);
    rstn_i = 1;
    bus(0, 1, 32'h00, 0, rd, ack, err);
    check("id", rd, ID);
    check("id_ack_err", {ack, err}, 2'b10);
    cyc(1);
    check("ack_idle", 32'(sys_ack), 0);
    bus(1, 0, 32'h30, 32'hA5, rd, ack, err);
    model_write(8'h30, 32'hA5);
    check("led", 32'(led_o), 32'hA5);
    bus(0, 1, 32'h50, 0, rd, ack, err);
    check("unmapped_err", {ack, err}, 2'b11);
    bus(1, 1, 32'h30, 32'h3C, rd, ack, err);
    check("rw_same_cycle_rd", rd, 32'hA5);
    model_write(8'h30, 32'h3C);
    check("rw_same_cycle_led", 32'(led_o), 32'h3C);
    @(posedge clk_i); #5;
    rstn_i = 0;
    #1;
    check("async_rst_led", 32'(led_o), 0);
    m_led = 0;
    @(posedge clk_i); #1;
    rstn_i = 1;
    bus(1, 0, 32'h10, 32'h1FF, rd, ack, err);
    model_write(8'h10, 32'h1FF);
    bus(1, 0, 32'h18, 32'h155, rd, ack, err);
    model_write(8'h18, 32'h155);
    check("exp_p_oe", 32'(exp_p_oe), 32'h1FF);
    check("exp_p_o", 32'(exp_p_o), 32'h155);
    exp_n_i = 9'h0AA;
    cyc(3);
    bus(0, 1, 32'h24, 0, rd, ack, err);
    check("exp_n_i", rd, 32'h0AA);
    q0.push_back(14'h0005); q1.push_back(14'h3FFA);
    for (int i = 0; i < 30; i++) begin q0.push_back(14'(i)); q1.push_back(14'($urandom)); end
    for (int i = 0; i < 20; i++) begin q0.push_back(14'($urandom)); q1.push_back(14'($urandom)); end
    n = q0.size();
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk_i); #1;
      if (k >= 2) begin
        check("adc0", 32'(adc_dat_o[0]), 32'(conv(q0[k-2])));
        check("adc1", 32'(adc_dat_o[1]), 32'(conv(q1[k-2])));
      end
      adc_dat_i[0] = k < n ? lane(q0[k], 0) : '0;
      adc_dat_i[1] = k < n ? lane(q1[k], 0) : '0;
      @(negedge clk_i); #1;
      adc_dat_i[0] = k < n ? lane(q0[k], 1) : '0;
      adc_dat_i[1] = k < n ? lane(q1[k], 1) : '0;
    end
    t0 = trig_seen;
    for (int i = 0; i < 3; i++) begin trig_i = 1; cyc(1200); trig_i = 0; cyc(1200); end
    check("trig_pulses", 32'(trig_seen - t0), 3);
    m_trig = 3;
    bus(0, 1, 32'h44, 0, rd, ack, err);
    check("trig_cnt", rd, m_trig);
    n = $urandom_range(2, 6);
    t0 = trig_seen;
    for (int i = 0; i < n; i++) begin
      trig_i = 1; cyc($urandom_range(3, 40)); trig_i = 0; cyc($urandom_range(4, 40));
    end
    m_trig += 32'(n);
    check("trig_pulses_rand", 32'(trig_seen - t0), 32'(n));
    bus(0, 1, 32'h44, 0, rd, ack, err);
    check("trig_cnt_rand", rd, m_trig);
    temp_prot_i = 2'b10;
    cyc(1000);
    check("temp_alarm", 32'(temp_alarm_o), 1);
    temp_prot_i = 2'b00;
    cyc(10);
    bus(0, 1, 32'h40, 0, rd, ack, err);
    check("temp_sticky", rd, 32'h1);
    temp_prot_i = 2'b01;
    cyc(5);
    bus(1, 0, 32'h40, 32'h1, rd, ack, err);
    cyc(1);
    check("temp_set_wins", 32'(temp_alarm_o), 1);
    temp_prot_i = 2'b00;
    cyc(5);
    bus(1, 0, 32'h40, 32'h1, rd, ack, err);
    bus(0, 1, 32'h40, 0, rd, ack, err);
    check("temp_clear", rd, 0);
    check("temp_alarm_clear", 32'(temp_alarm_o), 0);
    for (int i = 0; i < 40; i++) begin
      exp_p_i = 9'($urandom);
      exp_n_i = 9'($urandom);
      cyc(3);
      case ($urandom_range(0, 10))
        0: ad = 32'h00; 1: ad = 32'h10; 2: ad = 32'h14; 3: ad = 32'h18; 4: ad = 32'h1C;
        5: ad = 32'h20; 6: ad = 32'h24; 7: ad = 32'h30; 8: ad = 32'h40; 9: ad = 32'h44;
        default: ad = $urandom;
      endcase
      ad[31:8] = 24'($urandom);
      d = $urandom;
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      bus(w, r, ad, d, rd, ack, err);
      check("rnd_ack", 32'(ack), 1);
      check("rnd_err", 32'(err), 32'(!is_mapped(ad[7:0])));
      if (r) check("rnd_rdata", rd, model_read(ad[7:0]));
      if (w) model_write(ad[7:0], d);
    end
    check("rnd_exp_out", {5'd0, exp_p_oe, exp_n_oe, exp_p_o}, {5'd0, m_poe, m_noe, m_po});
    check("rnd_exp_n_o_led", {exp_n_o, led_o}, {m_no, m_led});
    pll_step(1001);
    pll_step(1400);
    for (int i = 0; i < 6; i++)
      case ($urandom_range(0, 2))
        0: pll_step($urandom_range(970, 1030));
        1: pll_step($urandom_range(1120, 1800));
        default: pll_step($urandom_range(400, 880));
      endcase
    pll_step(1001);
    pll_step(600);
    ref_period = 0;
    cyc(4 * NOM + 100);
    check("pll_tmo_outs", {pll_hi_o, pll_lo_o}, 0);
    bus(0, 1, 32'h40, 0, rd, ack, err);
    check("pll_tmo_lock", 32'(rd[1]), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
